// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops and optional iterative unsigned mul/div.
// Define ALU_MULDIV_EN to build the iterative MUL/MULHU/DIVU/REMU datapath.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// BUSY  | iterating mul/div, one bit per cycle
// DONE  | result valid, held until out_ready
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   add_ext, sub_ext;
  logic             slt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_carry, sc_ovf, sc_illegal;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d, ill_d;
  logic             load_res;

  assign slt = $signed(in1) < $signed(in2);

`ifdef ALU_MULDIV_EN
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  logic             is_iter, start_iter;
  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [1:0]       op_q;
  logic [SW-1:0]    cnt;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo, iter_result;
  logic             div_ge;
`endif

  // Single-cycle datapath, evaluated straight from the operand inputs
  always_comb begin
    add_ext    = {1'b0, in1} + {1'b0, in2};
    sub_ext    = {1'b0, in1} - {1'b0, in2};
    sc_result  = '0;
    sc_carry   = 1'b0;
    sc_ovf     = 1'b0;
    sc_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
    is_iter    = 1'b0;
`endif
    case (alu_control)
      4'b0000: sc_result = in1 & in2;
      4'b0001: sc_result = in1 | in2;
      4'b0011: sc_result = in1 ^ in2;
      4'b0100: sc_result = in1 << in2[SW-1:0];
      4'b0101: sc_result = in1 >> in2[SW-1:0];
      4'b0010: begin
        sc_result = add_ext[WIDTH-1:0];
        sc_carry  = add_ext[WIDTH];
        sc_ovf    = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0110: begin
        sc_result = sub_ext[WIDTH-1:0];
        sc_carry  = sub_ext[WIDTH];
        sc_ovf    = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_ext[WIDTH-1] != in1[WIDTH-1]);
      end
      4'b0111: begin
        sc_result = {{(WIDTH-1){1'b0}}, slt};
        sc_carry  = sub_ext[WIDTH];
      end
`ifdef ALU_MULDIV_EN
      4'b1000, 4'b1001, 4'b1010, 4'b1011: is_iter = 1'b1;
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared accumulator: product {hi,lo} for multiply, {remainder,quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb};
    div_diff  = div_shift[WIDTH-1:0] - opb;
    if (op_q[1]) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    iter_result = op_q[0] ? step_hi : step_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      op_q   <= '0;
      cnt    <= '0;
    end else if (start_iter) begin
      acc_hi <= '0;
      acc_lo <= in1;
      opb    <= in2;
      op_q   <= alu_control[1:0];
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + SW'(1);
    end
  end
`endif

  always_comb begin
    res_d   = sc_result;
    carry_d = sc_carry;
    ovf_d   = sc_ovf;
    ill_d   = sc_illegal;
`ifdef ALU_MULDIV_EN
    if (state == BUSY) begin
      res_d   = iter_result;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    load_res  = 1'b0;
`ifdef ALU_MULDIV_EN
    start_iter = 1'b0;
`endif
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: begin
`ifdef ALU_MULDIV_EN
        if (cnt == CNT_LAST) begin
          load_res  = 1'b1;
          state_nxt = DONE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (in_valid && in_ready) begin
`ifdef ALU_MULDIV_EN
      if (is_iter) begin
        start_iter = 1'b1;
        state_nxt  = BUSY;
      end else
`endif
      begin
        load_res  = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_result <= '0;
      zero_flag  <= 1'b0;
      neg_flag   <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_res) begin
        alu_result <= res_d;
        zero_flag  <= (res_d == '0);
        neg_flag   <= res_d[WIDTH-1];
        carry_flag <= carry_d;
        ovf_flag   <= ovf_d;
        illegal_op <= ill_d;
      end
    end
  end

  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus random ops against an arithmetic model.
// Follows ALU_MULDIV_EN so the same bench covers both builds.
module tb_alu_mc;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [3:0]   alu_control = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_result;
  logic         zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op;

  int n_cmp = 0;
  int n_bad = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .carry_flag(carry_flag),
    .ovf_flag(ovf_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ill;
    logic         ovf;
    logic         carry;
    logic [W-1:0] r;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, s;
    logic [63:0] p, ua, ub;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = ua * ub;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0011: e.r = a ^ b;
      4'b0100: e.r = a << b[4:0];
      4'b0101: e.r = a >> b[4:0];
      4'b0010: begin
        e.r = a + b; s = sa + sb;
        e.carry = (ua + ub) > 64'hFFFF_FFFF;
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      4'b0110: begin
        e.r = a - b; s = sa - sb;
        e.carry = ua < ub;
        e.ovf = (s > SMAX) || (s < SMIN);
      end
      4'b0111: begin
        e.r = (sa < sb) ? 32'd1 : 32'd0;
        e.carry = ua < ub;
      end
      4'b1000: if (MD) e.r = p[31:0];  else e.ill = 1'b1;
      4'b1001: if (MD) e.r = p[63:32]; else e.ill = 1'b1;
      4'b1010: if (MD) e.r = (b == 0) ? 32'hFFFF_FFFF : a / b; else e.ill = 1'b1;
      4'b1011: if (MD) e.r = (b == 0) ? a : a % b;            else e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_res"}, {32'b0, alu_result}, {32'b0, e.r});
    // flag vector: zero, neg, carry, ovf, illegal
    chk({tag, "_flags"}, {59'b0, zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op},
        {59'b0, (e.r == 0), e.r[W-1], e.carry, e.ovf, e.ill});
  endtask

  // One op from IDLE with out_ready=1; checks latency, result and flags, returns to IDLE
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, lat;
    exp_t e;
    e   = model(op, a, b);
    lat = (MD && op[3:2] == 2'b10) ? W : 0;
    chk({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
    alu_control = op; in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (cyc == 1) chk({tag, "_busy_rdy"}, {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk_out(tag, e);
    @(posedge clk); #1;
  endtask

  logic [3:0]   b2b_op [3] = '{4'b0010, 4'b0110, 4'b0110};
  logic [W-1:0] b2b_a  [3] = '{32'h7FFF_FFFF, 32'd5, 32'd3};
  logic [W-1:0] b2b_b  [3] = '{32'd1, 32'd5, 32'd5};
  logic [3:0]   legal  [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111,
                                4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
  logic [3:0]   single [8]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111,
                                4'b0100, 4'b0101};

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 40));
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    exp_t e;
    logic seen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    // reset state
    #12;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_res", {32'b0, alu_result}, 64'd0);
    chk("rst_flags", {59'b0, zero_flag, neg_flag, carry_flag, ovf_flag, illegal_op}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {63'b0, in_ready}, 64'd1);

    // back-to-back single-cycle ops
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_control = b2b_op[i]; in1 = b2b_a[i]; in2 = b2b_b[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      chk_out($sformatf("b2b%0d", i), model(b2b_op[i], b2b_a[i], b2b_b[i]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {63'b0, out_valid}, 64'd0);

    // backpressure: AND held for 4 cycles while a pending XOR waits
    out_ready = 1'b0;
    alu_control = 4'b0000; in1 = 32'hF0F0_F0F0; in2 = 32'hFF00_FF00; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_control = 4'b0011; in1 = 32'h1234_5678; in2 = 32'h0F0F_0F0F;
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("bp%0d", i), model(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00));
      chk($sformatf("bp%0d_rdy", i), {63'b0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp_next", model(4'b0011, 32'h1234_5678, 32'h0F0F_0F0F));
    @(posedge clk); #1;

    // directed mul/div and illegal opcodes
    run_op("mul",   4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu",  4'b1010, 32'd100, 32'd7);
    run_op("remu",  4'b1011, 32'd100, 32'd7);
    run_op("divu0", 4'b1010, 32'hDEAD_BEEF, 32'd0);
    run_op("remu0", 4'b1011, 32'd9, 32'd0);
    run_op("ill15", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("ill8",  4'b1000, 32'd3, 32'd4);
    run_op("slt",   4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_op("sll",   4'b0100, 32'h0000_0001, 32'hFFFF_FFFF);

    // reset mid-operation
    out_ready = 1'b0;
    alu_control = 4'b1000; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_res", {32'b0, alu_result}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy", {63'b0, in_ready}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_out", {63'b0, seen}, 64'd0);

    // random single-cycle ops at full throughput
    for (int i = 0; i < 30; i++) begin
      op = single[$urandom_range(0, 7)];
      a = rand_operand(); b = rand_operand();
      alu_control = op; in1 = a; in2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      chk_out($sformatf("rb2b%0d_op%0h", i, op), model(op, a, b));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // random mix including mul/div and undefined opcodes
    for (int i = 0; i < 50; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 11)];
      a = rand_operand(); b = rand_operand();
      run_op($sformatf("rnd%0d_op%0h", i, op), op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
